// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM DMA engine: FSM encoding, transfer
// modes and default bus widths.
package sram_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 32;

   localparam logic MODE_COPY = 1'b0;
   localparam logic MODE_FILL = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/byte_mask_gen.sv
// Byte-lane write mask for the current word: all four lanes while at least a
// full word remains, otherwise only the low lanes covering the tail.
module byte_mask_gen #(
   parameter int ADDR_W = 16
) (
   input  logic [ADDR_W-1:0] remaining,
   output logic [3:0]        mask
);

   always_comb begin
      mask = 4'b1111;
      if (remaining < ADDR_W'(4)) begin
         case (remaining[1:0])
            2'd1:    mask = 4'b0001;
            2'd2:    mask = 4'b0011;
            2'd3:    mask = 4'b0111;
            default: mask = 4'b0000;
         endcase
      end
   end

endmodule

// File: rtl/sram_dma_engine.sv
// Word-at-a-time SRAM copy/fill engine driving an external SRAM with
// combinational read data and per-byte write enables.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; all SRAM outputs parked at zero
// S_READ  | copy only: present src, capture read word into data register
// S_WRITE | present dst and write data, advance pointers, consume bytes
// S_DONE  | one-cycle done pulse, then back to idle
module sram_dma_engine
   import sram_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [ADDR_W-1:0] len,
   input  logic [DATA_W-1:0] fill_data,
   output logic              busy,
   output logic              done,
   output logic [3:0]        mem_w_en,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   input  logic [DATA_W-1:0] mem_read_data
);

   state_t              state, state_nxt;
   logic                mode_q;
   logic [ADDR_W-1:0]   src_q, dst_q, rem_q, rem_nxt;
   logic [DATA_W-1:0]   fill_q, data_q;
   logic [3:0]          tail_mask;

   byte_mask_gen #(.ADDR_W(ADDR_W)) u_mask (
      .remaining (rem_q),
      .mask      (tail_mask)
   );

   // Remaining count saturates at zero on the last, possibly partial, word.
   assign rem_nxt = (rem_q >= ADDR_W'(4)) ? rem_q - ADDR_W'(4) : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      busy           = 1'b1;
      done           = 1'b0;
      mem_w_en       = 4'b0000;
      mem_address    = '0;
      mem_write_data = '0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               if (len == '0)              state_nxt = S_DONE;
               else if (mode == MODE_FILL) state_nxt = S_WRITE;
               else                        state_nxt = S_READ;
            end
         end
         S_READ: begin
            mem_address = src_q;
            state_nxt   = S_WRITE;
         end
         S_WRITE: begin
            mem_address    = dst_q;
            mem_w_en       = tail_mask;
            mem_write_data = (mode_q == MODE_FILL) ? fill_q : data_q;
            if (rem_nxt == '0)            state_nxt = S_DONE;
            else if (mode_q == MODE_FILL) state_nxt = S_WRITE;
            else                          state_nxt = S_READ;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mode_q <= MODE_COPY;
         src_q  <= '0;
         dst_q  <= '0;
         rem_q  <= '0;
         fill_q <= '0;
         data_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  mode_q <= mode;
                  src_q  <= src_addr;
                  dst_q  <= dst_addr;
                  rem_q  <= len;
                  fill_q <= fill_data;
               end
            end
            S_READ: data_q <= mem_read_data;
            S_WRITE: begin
               src_q <= src_q + ADDR_W'(4);
               dst_q <= dst_q + ADDR_W'(4);
               rem_q <= rem_nxt;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_dma_engine.sv
// Directed bench for sram_dma_engine with a byte-addressed SRAM model and a
// scoreboard of expected write beats and done-pulse cycles.
module tb_sram_dma_engine;

   localparam logic MC = 1'b0;
   localparam logic MF = 1'b1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        mode;
   logic [15:0] src_addr, dst_addr, len;
   logic [31:0] fill_data;
   logic        busy, done;
   logic [3:0]  mem_w_en;
   logic [15:0] mem_address;
   logic [31:0] mem_write_data, mem_read_data;

   typedef struct {
      logic [15:0] addr;
      logic [3:0]  wen;
      logic [31:0] data;
   } wr_t;

   wr_t exp_wr[$];
   int  exp_done[$];
   int  cyc = 0;
   int  n_checks = 0;
   int  n_fail = 0;
   logic [7:0] mem [0:65535];

   sram_dma_engine #(.ADDR_W(16), .DATA_W(32)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .mode           (mode),
      .src_addr       (src_addr),
      .dst_addr       (dst_addr),
      .len            (len),
      .fill_data      (fill_data),
      .busy           (busy),
      .done           (done),
      .mem_w_en       (mem_w_en),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // SRAM model: combinational read, byte-lane write on the rising edge.
   always_comb begin
      mem_read_data = {mem[16'(mem_address + 16'd3)], mem[16'(mem_address + 16'd2)],
                       mem[16'(mem_address + 16'd1)], mem[mem_address]};
   end

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (mem_w_en[i]) mem[16'(mem_address + 16'(i))] <= mem_write_data[8*i +: 8];
   end

   function automatic logic [31:0] rd_word(input logic [15:0] a);
      return {mem[16'(a + 16'd3)], mem[16'(a + 16'd2)], mem[16'(a + 16'd1)], mem[a]};
   endfunction

   task automatic wr_word(input logic [15:0] a, input logic [31:0] d);
      for (int i = 0; i < 4; i++) mem[16'(a + 16'(i))] = d[8*i +: 8];
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_wr(input logic [15:0] a, input logic [3:0] w, input logic [31:0] d);
      wr_t t;
      t.addr = a; t.wen = w; t.data = d;
      exp_wr.push_back(t);
   endtask

   // Monitor: every write beat and done pulse must match the head of its queue.
   always @(negedge clk) begin
      if (mem_w_en != 4'b0000) begin
         if (exp_wr.size() == 0) begin
            chk("unexpected_write_addr", {16'h0, mem_address}, 32'hFFFF_FFFF);
         end else begin
            wr_t e;
            e = exp_wr.pop_front();
            chk("write_addr", {16'h0, mem_address}, {16'h0, e.addr});
            chk("write_wen", {28'h0, mem_w_en}, {28'h0, e.wen});
            chk("write_data", mem_write_data, e.data);
         end
      end
      if (done) begin
         if (exp_done.size() == 0) chk("unexpected_done_cycle", cyc, -1);
         else chk("done_cycle", cyc, exp_done.pop_front());
      end
   end

   // Start is high during the cycle numbered cyc at this negedge; done is
   // expected lat cycles later (lat < 0 means no done is expected).
   task automatic issue(input logic m, input logic [15:0] s, input logic [15:0] d,
                        input logic [15:0] l, input logic [31:0] f, input int lat);
      @(negedge clk);
      mode = m; src_addr = s; dst_addr = d; len = l; fill_data = f; start = 1'b1;
      if (lat >= 0) exp_done.push_back(cyc + lat);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk({name, "_timeout"}, 32'd1, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; mode = MC;
      src_addr = '0; dst_addr = '0; len = '0; fill_data = '0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'h0, busy}, 32'd0);
      chk("rst_done", {31'h0, done}, 32'd0);
      chk("rst_wen", {28'h0, mem_w_en}, 32'd0);
      chk("rst_addr", {16'h0, mem_address}, 32'd0);
      chk("rst_wdata", mem_write_data, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Fill two full words.
      push_wr(16'h0100, 4'hF, 32'hDEADBEEF);
      push_wr(16'h0104, 4'hF, 32'hDEADBEEF);
      issue(MF, 16'h0, 16'h0100, 16'd8, 32'hDEADBEEF, 3);
      chk("fill_busy", {31'h0, busy}, 32'd1);
      wait_idle("fill");
      chk("fill_w0", rd_word(16'h0100), 32'hDEADBEEF);
      chk("fill_w1", rd_word(16'h0104), 32'hDEADBEEF);

      // Copy two words.
      wr_word(16'h0000, 32'h11223344);
      wr_word(16'h0004, 32'h55667788);
      push_wr(16'h0200, 4'hF, 32'h11223344);
      push_wr(16'h0204, 4'hF, 32'h55667788);
      issue(MC, 16'h0000, 16'h0200, 16'd8, 32'h0, 5);
      chk("copy_read_addr", {16'h0, mem_address}, 32'h0000_0000);
      @(negedge clk);
      wait_idle("copy");
      chk("copy_w0", rd_word(16'h0200), 32'h11223344);
      chk("copy_w1", rd_word(16'h0204), 32'h55667788);

      // Partial tail: 6 bytes, upper two bytes of the second word untouched.
      wr_word(16'h0300, 32'hFFFFFFFF);
      wr_word(16'h0304, 32'hFFFFFFFF);
      push_wr(16'h0300, 4'hF, 32'hDEADBEEF);
      push_wr(16'h0304, 4'h3, 32'hDEADBEEF);
      issue(MF, 16'h0, 16'h0300, 16'd6, 32'hDEADBEEF, 3);
      wait_idle("tail");
      chk("tail_w0", rd_word(16'h0300), 32'hDEADBEEF);
      chk("tail_w1", rd_word(16'h0304), 32'hFFFFBEEF);

      // Destination wraps past the top of the address space.
      push_wr(16'hFFFC, 4'hF, 32'hCAFEF00D);
      push_wr(16'h0000, 4'hF, 32'hCAFEF00D);
      issue(MF, 16'h0, 16'hFFFC, 16'd8, 32'hCAFEF00D, 3);
      wait_idle("wrap");
      chk("wrap_w0", rd_word(16'hFFFC), 32'hCAFEF00D);
      chk("wrap_w1", rd_word(16'h0000), 32'hCAFEF00D);

      // Zero length: done next cycle, no write.
      wr_word(16'h0800, 32'h12345678);
      issue(MF, 16'h0, 16'h0800, 16'd0, 32'hAAAAAAAA, 1);
      wait_idle("len0");
      chk("len0_mem", rd_word(16'h0800), 32'h12345678);

      // Reset during the second READ of a four-word copy.
      wr_word(16'h0400, 32'hA0A1A2A3);
      wr_word(16'h0404, 32'hB0B1B2B3);
      wr_word(16'h0408, 32'hC0C1C2C3);
      wr_word(16'h040C, 32'hD0D1D2D3);
      for (int i = 0; i < 4; i++) wr_word(16'h0500 + 16'(4*i), 32'h5A5A5A5A);
      push_wr(16'h0500, 4'hF, 32'hA0A1A2A3);
      issue(MC, 16'h0400, 16'h0500, 16'd16, 32'h0, -1);
      @(negedge clk);
      @(negedge clk);
      chk("abort_read2_addr", {16'h0, mem_address}, 32'h0000_0404);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_wen", {28'h0, mem_w_en}, 32'd0);
      chk("abort_busy", {31'h0, busy}, 32'd0);
      chk("abort_addr", {16'h0, mem_address}, 32'd0);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("abort_w0", rd_word(16'h0500), 32'hA0A1A2A3);
      chk("abort_w1", rd_word(16'h0504), 32'h5A5A5A5A);
      chk("abort_w2", rd_word(16'h0508), 32'h5A5A5A5A);
      chk("abort_w3", rd_word(16'h050C), 32'h5A5A5A5A);

      // Start while busy is ignored.
      push_wr(16'h0600, 4'hF, 32'h01020304);
      push_wr(16'h0604, 4'hF, 32'h01020304);
      push_wr(16'h0608, 4'hF, 32'h01020304);
      issue(MF, 16'h0, 16'h0600, 16'd12, 32'h01020304, 4);
      mode = MC; src_addr = 16'h0000; dst_addr = 16'h0700; len = 16'd4;
      fill_data = 32'hFFFFFFFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle("rebusy");
      repeat (3) @(negedge clk);
      chk("rebusy_w2", rd_word(16'h0608), 32'h01020304);
      chk("rebusy_untouched", rd_word(16'h0700), 32'h00000000);

      chk("writes_left", exp_wr.size(), 32'd0);
      chk("dones_left", exp_done.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sram_dma_engine.md
SRAM_DMA_ENGINE -- requirements
Module: sram_dma_engine

Interface
REQ-001 Parameter ADDR_W, default 16, SRAM byte-address width; all address arithmetic is modulo 2^ADDR_W.
REQ-002 Parameter DATA_W, default 32, SRAM word width; fixed at 4 byte lanes.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request pulse; sampled only in IDLE.
REQ-006 mode  input  1  0 = copy, 1 = fill; sampled with start.
REQ-007 src_addr  input  ADDR_W  copy source byte address; sampled with start.
REQ-008 dst_addr  input  ADDR_W  destination byte address; sampled with start.
REQ-009 len  input  ADDR_W  transfer length in bytes; sampled with start.
REQ-010 fill_data  input  32  fill pattern; sampled with start.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  single-cycle completion pulse.
REQ-013 mem_w_en  output  4  SRAM byte-lane write enables; bit i writes byte address+i.
REQ-014 mem_address  output  ADDR_W  SRAM byte address.
REQ-015 mem_write_data  output  32  SRAM write data; byte i on bits 8i+7:8i.
REQ-016 mem_read_data  input  32  SRAM combinational read data for mem_address.

Function
REQ-017 The FSM SHALL have states IDLE, READ, WRITE, DONE.
REQ-018 In IDLE, start=1 SHALL latch all inputs of REQ-006..010 and go to DONE if len=0, otherwise to READ (copy) or WRITE (fill).
REQ-019 READ SHALL drive mem_address=current src, mem_w_en=0, capture mem_read_data into the data register at cycle end, then go to WRITE.
REQ-020 WRITE SHALL drive mem_address=current dst, mem_write_data=data register (copy) or latched fill_data (fill), and mem_w_en per REQ-021.
REQ-021 mem_w_en in WRITE SHALL be 4'b1111 when remaining>=4, else 4'b0001/0011/0111 for remaining=1/2/3.
REQ-022 After each WRITE, src and dst SHALL each advance by 4 (wrapping modulo 2^ADDR_W), remaining SHALL decrease by min(4,remaining); next state is DONE if remaining becomes 0, else READ (copy) or WRITE (fill).
REQ-023 DONE SHALL assert done=1 for exactly one cycle and return to IDLE.
REQ-024 Latency: copy of W words = 2W+1 cycles from start to done; fill = W+1; len=0 = 1.
REQ-025 mem_w_en SHALL be 0 in IDLE, READ and DONE; no SRAM write occurs outside WRITE.
REQ-026 start outside IDLE SHALL be ignored with no effect on the transfer in progress.
REQ-027 Addresses need no alignment; overlapping copy regions proceed strictly in ascending word order with no hazard handling.
REQ-028 mem_address SHALL equal latched src in READ, dst in WRITE, and 0 in IDLE and DONE.

Reset
REQ-029 rst_n=0 at a rising edge SHALL force IDLE, busy=0, done=0, mem_w_en=0, mem_address=0, mem_write_data=0, and clear the data register and counters, including mid-transfer.
REQ-030 An aborted transfer SHALL not generate done.

Structure
REQ-031 State encoding, mode constants (MODE_COPY, MODE_FILL), and the ADDR_W/DATA_W defaults SHALL reside in shared package sram_pkg.
REQ-032 The tail-mask function of REQ-021 SHALL be a sub-module byte_mask_gen (remaining in, 4-bit mask out).
REQ-033 The block SHALL instantiate no SRAM; the bench connects it to the team SRAM model.

Verification
REQ-034 Fill, dst=0x0100, len=8, fill_data=0xDEADBEEF -> words at 0x0100 and 0x0104 read 0xDEADBEEF; done at cycle 3 after start.
REQ-035 Copy, src=0x0000 holding 0x11223344 and 0x55667788, dst=0x0200, len=8 -> 0x0200/0x0204 match; done at cycle 5.
REQ-036 Fill, dst=0x0300, len=6, preload 0xFFFFFFFF -> 0x0304 reads 0xFFFF_BEEF pattern-upper intact: bytes 0x0304-0x0305 written, 0x0306-0x0307 still 0xFF; second WRITE has w_en=4'b0011.
REQ-037 Fill, dst=0xFFFC, len=8 -> writes at 0xFFFC then 0x0000; len=0 -> done next cycle, no write.
REQ-038 rst_n=0 during the second READ of a 4-word copy -> w_en=0 next cycle, IDLE, no done, remaining destination words unchanged.
REQ-039 start reasserted while busy -> ignored; original transfer completes with correct data and one done pulse.
